// File: rtl/instruction_fetch.sv
//------------------------------------------------------------------------------
// Module      : instruction_fetch
// Description : Sequential instruction fetch with 2-entry prefetch queue,
//               decode back-pressure and redirect with in-flight drop.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_STEP  = 4
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_Stall,
    input  logic        i_Redirect,
    input  logic [31:0] i_RedirectPc,
    output logic        o_MemReq,
    output logic [31:0] o_MemAddr,
    input  logic        i_MemAck,
    input  logic [31:0] i_MemData,
    output logic [31:0] o_InstructionRegister,
    output logic        o_IrValid,
    output logic [31:0] o_IrPc
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_drop_addr;
    logic [31:0] r_instr [2];
    logic [31:0] r_pc    [2];
    logic [1:0]  r_count;
    logic [1:0]  w_count_next;
    logic        w_push;
    logic        w_pop;
    logic        w_wr_idx;

    always_comb begin
        w_push       = (r_state == ST_REQ) && i_MemAck && !i_Redirect;
        w_pop        = (r_count != 2'd0) && !i_Stall;
        // Slot receiving a push, accounting for a same-cycle pop shifting the head
        w_wr_idx     = w_pop ? (r_count == 2'd2) : (r_count == 2'd1);
        w_count_next = r_count;
        if (i_Redirect) begin
            w_count_next = 2'd0;
        end else if (w_push && !w_pop) begin
            w_count_next = r_count + 2'd1;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - 2'd1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_count_next <= 2'd1) w_state_next = ST_REQ;
            end
            ST_REQ: begin
                if (i_Redirect) begin
                    w_state_next = i_MemAck ? ST_REQ : ST_DROP;
                end else if (i_MemAck) begin
                    w_state_next = (w_count_next <= 2'd1) ? ST_REQ : ST_IDLE;
                end
            end
            ST_DROP: begin
                if (i_MemAck) w_state_next = ST_REQ;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_state     <= ST_IDLE;
            r_fetch_pc  <= RESET_PC;
            r_drop_addr <= RESET_PC;
            r_count     <= 2'd0;
            r_instr[0]  <= 32'd0;
            r_instr[1]  <= 32'd0;
            r_pc[0]     <= 32'd0;
            r_pc[1]     <= 32'd0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            if (i_Redirect) begin
                r_fetch_pc <= {i_RedirectPc[31:2], 2'b00};
                // The outstanding request keeps its address until the late ack
                if (r_state == ST_REQ && !i_MemAck) r_drop_addr <= r_fetch_pc;
            end else begin
                if (w_pop && r_count == 2'd2) begin
                    r_instr[0] <= r_instr[1];
                    r_pc[0]    <= r_pc[1];
                end
                if (w_push) begin
                    r_instr[w_wr_idx] <= i_MemData;
                    r_pc[w_wr_idx]    <= r_fetch_pc;
                    r_fetch_pc        <= r_fetch_pc + 32'(PC_STEP);
                end
            end
            a_no_overflow: assert (!(w_push && r_count == 2'd2))
                else $error("instruction_fetch: push into full queue");
        end
    end

    always_comb begin
        o_MemReq              = (r_state != ST_IDLE);
        o_MemAddr             = (r_state == ST_DROP) ? r_drop_addr : r_fetch_pc;
        o_IrValid             = (r_count != 2'd0);
        o_InstructionRegister = o_IrValid ? r_instr[0] : 32'd0;
        o_IrPc                = o_IrValid ? r_pc[0]    : 32'd0;
    end

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
//------------------------------------------------------------------------------
// Module      : tb_instruction_fetch
// Description : Directed + randomized bench for instruction_fetch against a
//               transaction-level queue model.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_instruction_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_data = 32'd0;
    logic [31:0] ir;
    logic        ir_valid;
    logic [31:0] ir_pc;

    ent_t        q[$];
    logic [31:0] m_fpc;
    logic [31:0] m_stale_addr;
    bit          m_busy;
    bit          m_stale;

    int vectors = 0;
    int miscompares = 0;
    int lat = 0;
    int wait_cnt = 0;
    bit force_ack = 0;
    bit rand_lat = 0;
    bit done;

    always #5 clk = ~clk;

    instruction_fetch #(.RESET_PC(RESET_PC), .PC_STEP(4)) dut (
        .i_Clk                 (clk),
        .i_Rst                 (rst),
        .i_Stall               (stall),
        .i_Redirect            (redirect),
        .i_RedirectPc          (redirect_pc),
        .o_MemReq              (mem_req),
        .o_MemAddr             (mem_addr),
        .i_MemAck              (mem_ack),
        .i_MemData             (mem_data),
        .o_InstructionRegister (ir),
        .o_IrValid             (ir_valid),
        .o_IrPc                (ir_pc)
    );

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [31:0] e_ir;
        logic [31:0] e_pc;
        e_ir = (q.size() != 0) ? q[0].instr : 32'd0;
        e_pc = (q.size() != 0) ? q[0].pc    : 32'd0;
        check_eq("mem_req",  32'(mem_req),  32'(m_busy));
        check_eq("mem_addr", mem_addr,      m_stale ? m_stale_addr : m_fpc);
        check_eq("ir_valid", 32'(ir_valid), 32'(q.size() != 0));
        check_eq("ir",       ir,            e_ir);
        check_eq("ir_pc",    ir_pc,         e_pc);
    endtask

    // Behaviour of one clock edge expressed on the instruction queue
    task automatic model_edge(input bit r, input bit st, input bit rd, input bit ack,
                              input logic [31:0] rpc, input logic [31:0] data);
        logic [31:0] tgt;
        tgt = {rpc[31:2], 2'b00};
        if (r) begin
            q.delete();
            m_fpc        = RESET_PC;
            m_stale_addr = RESET_PC;
            m_busy       = 0;
            m_stale      = 0;
        end else if (rd) begin
            q.delete();
            if (m_busy && !m_stale && !ack) begin
                m_stale      = 1;
                m_stale_addr = m_fpc;
            end else if (m_stale && ack) begin
                m_stale = 0;
            end else if (!m_busy) begin
                m_busy = 1;
            end
            m_fpc = tgt;
        end else begin
            if (q.size() != 0 && !st) void'(q.pop_front());
            if (m_busy && m_stale) begin
                if (ack) m_stale = 0;
            end else if (m_busy) begin
                if (ack) begin
                    q.push_back('{instr: data, pc: m_fpc});
                    m_fpc  = m_fpc + 32'd4;
                    m_busy = (q.size() <= 1);
                end
            end else begin
                m_busy = (q.size() <= 1);
            end
        end
    endtask

    task automatic step(input bit r, input bit st, input bit rd, input logic [31:0] rpc);
        bit req_pre;
        check_outputs();
        rst         = r;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        mem_ack     = force_ack || (mem_req && wait_cnt >= lat);
        mem_data    = word_of(mem_addr);
        req_pre     = mem_req;
        @(posedge clk);
        model_edge(r, st, rd, mem_ack, rpc, mem_data);
        if (r || !req_pre || mem_ack) wait_cnt = 0;
        else wait_cnt++;
        if (mem_ack && rand_lat) lat = $urandom_range(0, 3);
        @(negedge clk);
        mem_ack   = 1'b0;
        force_ack = 1'b0;
    endtask

    initial begin
        model_edge(1, 0, 0, 0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset values, then zero-wait streaming
        step(1, 0, 0, 32'd0);
        step(1, 0, 0, 32'd0);
        lat = 0;
        repeat (10) step(0, 0, 0, 32'd0);

        // Stall from reset: queue fills, request drops, head holds
        step(1, 0, 0, 32'd0);
        repeat (7) step(0, 1, 0, 32'd0);
        repeat (4) step(0, 0, 0, 32'd0);

        // Redirect while a slow request is outstanding
        lat  = 3;
        done = 0;
        for (int i = 0; i < 12; i++) begin
            if (!done && mem_req && wait_cnt == 1) begin
                step(0, 0, 1, 32'h100);
                done = 1;
            end else begin
                step(0, 0, 0, 32'd0);
            end
        end
        repeat (10) step(0, 0, 0, 32'd0);

        // Redirect coincident with a zero-wait ack, unaligned target
        lat = 0;
        repeat (3) step(0, 0, 0, 32'd0);
        step(0, 0, 1, 32'h203);
        repeat (4) step(0, 0, 0, 32'd0);

        // Redirect and stall together with a full queue
        repeat (5) step(0, 1, 0, 32'd0);
        step(0, 1, 1, 32'h40);
        repeat (3) step(0, 0, 0, 32'd0);

        // Reset while dropping; late ack afterwards is ignored
        lat  = 3;
        done = 0;
        for (int i = 0; i < 12 && !done; i++) begin
            if (mem_req && wait_cnt == 0) begin
                step(0, 0, 1, 32'h300);
                done = 1;
            end else begin
                step(0, 0, 0, 32'd0);
            end
        end
        step(0, 0, 0, 32'd0);
        step(1, 0, 0, 32'd0);
        force_ack = 1;
        step(0, 0, 0, 32'd0);
        repeat (6) step(0, 0, 0, 32'd0);

        // Randomized traffic
        rand_lat = 1;
        repeat (400) step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 3,
                          $urandom_range(0, 19) == 0, $urandom);
        check_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
